// File: rtl/encrypt_pipe.sv
// encrypt_pipe: byte encryption pipeline (classify -> Caesar shift -> rotating-key XOR).
// The input byte is registered first, then it passes through the classify, shift and XOR
// stages, so a byte sampled with en at edge N shows up on v/dout after edge N+3.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset
//   en, din[7:0]        plaintext byte and its valid strobe
//   k1, k2, k3 [7:0]    XOR keys, sampled by the XOR stage
//   rot_freq[2:0]       bytes per key before rotating, 0 = k1 only
//   shift_en            enable alphabetic shift (sampled by the shift stage)
//   shift_amt[2:0]      shift distance 0..7
//   mode                0 = shift forward, 1 = shift backward
//   v, dout[7:0]        ciphertext byte and its valid strobe; dout holds when v = 0
//
// Configuration macro: ENCRYPT_KEY_ROT_EN
//   defined     -> k1/k2/k3 rotation driven by rot_freq
//   not defined -> every byte is XORed with k1, rot_freq ignored
module encrypt_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  input  logic [7:0] k3,
  input  logic [2:0] rot_freq,
  input  logic       shift_en,
  input  logic [2:0] shift_amt,
  input  logic       mode,
  output logic       v,
  output logic [7:0] dout
);

  // Input capture
  logic       s0_valid_q, s0_valid_d;
  logic [7:0] s0_data_q, s0_data_d;
  // Classify stage
  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_data_q, s1_data_d;
  logic       s1_upper_q, s1_upper_d;
  logic       s1_lower_q, s1_lower_d;
  // Shift stage
  logic       s2_valid_q, s2_valid_d;
  logic [7:0] s2_data_q, s2_data_d;
  // XOR stage / outputs
  logic       v_q, v_d;
  logic [7:0] dout_q, dout_d;

  logic [7:0] fwd_sum, back_diff, shifted;
  logic [7:0] key_sel;

  always_comb begin
    s0_valid_d = en;
    s0_data_d  = en ? din : s0_data_q;

    s1_valid_d = s0_valid_q;
    s1_data_d  = s1_data_q;
    s1_upper_d = s1_upper_q;
    s1_lower_d = s1_lower_q;
    if (s0_valid_q) begin
      s1_data_d  = s0_data_q;
      s1_upper_d = (s0_data_q >= 8'h41) && (s0_data_q <= 8'h5a);
      s1_lower_d = (s0_data_q >= 8'h61) && (s0_data_q <= 8'h7a);
    end
  end

  // Shift stays inside the byte's own case range; amt <= 7 keeps the 8-bit math in range.
  always_comb begin
    fwd_sum   = s1_data_q + {5'd0, shift_amt};
    back_diff = s1_data_q - {5'd0, shift_amt};
    shifted   = s1_data_q;
    if (shift_en && (s1_upper_q || s1_lower_q)) begin
      if (!mode) begin
        shifted = fwd_sum;
        if (fwd_sum > (s1_upper_q ? 8'h5a : 8'h7a)) shifted = fwd_sum - 8'd26;
      end else begin
        shifted = back_diff;
        if (back_diff < (s1_upper_q ? 8'h41 : 8'h61)) shifted = back_diff + 8'd26;
      end
    end
    s2_valid_d = s1_valid_q;
    s2_data_d  = s1_valid_q ? shifted : s2_data_q;
  end

`ifdef ENCRYPT_KEY_ROT_EN
  typedef enum logic [1:0] {KeyK1, KeyK2, KeyK3} key_ptr_e;
  key_ptr_e   ptr_q, ptr_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    key_sel = k1;
    if (rot_freq != 3'd0) begin
      unique case (ptr_q)
        KeyK2:   key_sel = k2;
        KeyK3:   key_sel = k3;
        default: key_sel = k1;
      endcase
    end
    // Pointer/count only move on valid bytes; >= lets a lowered rot_freq rotate at once.
    if (s2_valid_q) begin
      if (rot_freq == 3'd0) begin
        ptr_d = KeyK1;
        cnt_d = 3'd0;
      end else if (cnt_q >= rot_freq - 3'd1) begin
        cnt_d = 3'd0;
        unique case (ptr_q)
          KeyK1:   ptr_d = KeyK2;
          KeyK2:   ptr_d = KeyK3;
          default: ptr_d = KeyK1;
        endcase
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= KeyK1;
      cnt_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_rot;
  assign unused_rot = ^{rot_freq, k2, k3};
  assign key_sel    = k1;
`endif

  always_comb begin
    v_d    = s2_valid_q;
    dout_d = s2_valid_q ? (s2_data_q ^ key_sel) : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= 8'h00;
      s1_valid_q <= 1'b0;
      s1_data_q  <= 8'h00;
      s1_upper_q <= 1'b0;
      s1_lower_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 8'h00;
      v_q        <= 1'b0;
      dout_q     <= 8'h00;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_upper_q <= s1_upper_d;
      s1_lower_q <= s1_lower_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      v_q        <= v_d;
      dout_q     <= dout_d;
    end
  end

  assign v    = v_q;
  assign dout = dout_q;

endmodule
